// File: rtl/join_chain_ctrl_pkg.sv
// Shared definitions for the join chain head/tail controller:
// controller state encoding, valid-bit index helper and default tuple widths.

`ifndef PARA_STREAM_TUPLE_WIDTH
`define PARA_STREAM_TUPLE_WIDTH 65
`endif
`ifndef PARA_WINDOW_TUPLE_WIDTH
`define PARA_WINDOW_TUPLE_WIDTH 65
`endif
`ifndef PARA_RESULT_PAIR_WIDTH
`define PARA_RESULT_PAIR_WIDTH 65
`endif

package join_chain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_WAIT_CLR = 3'd4
  } ctrl_state_e;

  // Chain tuples carry their valid flag in the MSB.
  function automatic int valid_idx(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/join_result_fifo.sv
// Synchronous result FIFO with occupancy count. Pushes while full and pops
// while empty are ignored; the caller decides what a dropped push means.

module join_result_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/join_chain_ctrl.sv
// Head/tail controller for a linear chain of join core stages.
// Feeds stream/window tuples into stage 0, collects result pairs from the
// last stage into a FIFO, throttles the tail via feedback, and sequences a
// flush-and-clear of the chain on request.
// Optional build macro: JOIN_CTRL_STATS_EN adds saturating statistics outputs.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | just out of reset or flush finished; moves to RUN next cycle
// RUN      | accepting inputs into the head registers
// DRAIN    | inputs closed; waiting for 2*STAGE_NUM consecutive quiet cycles
// CLEAR    | one-cycle clear pulse into stage 0
// WAIT_CLR | STAGE_NUM+1 cycles for the clear to ripple; flush_done on last

module join_chain_ctrl
  import join_chain_ctrl_pkg::*;
#(
  parameter int STREAM_TUPLE_WIDTH = `PARA_STREAM_TUPLE_WIDTH,
  parameter int WINDOW_TUPLE_WIDTH = `PARA_WINDOW_TUPLE_WIDTH,
  parameter int RESULT_PAIR_WIDTH  = `PARA_RESULT_PAIR_WIDTH,
  parameter int STAGE_NUM          = 16,
  parameter int RESULT_FIFO_DEPTH  = 16,
  parameter int STALL_MARGIN       = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [STREAM_TUPLE_WIDTH-2:0] s_stream_tdata,
  input  logic                          s_stream_tvalid,
  output logic                          s_stream_tready,
  input  logic [WINDOW_TUPLE_WIDTH-2:0] s_window_tdata,
  input  logic                          s_window_tvalid,
  output logic                          s_window_tready,
  output logic [STREAM_TUPLE_WIDTH-1:0] stream_tuple_head,
  input  logic                          stream_stage_full_head,
  output logic                          stream_stage_clear_head,
  output logic [WINDOW_TUPLE_WIDTH-1:0] window_tuple_head,
  input  logic                          window_stage_full_head,
  input  logic [RESULT_PAIR_WIDTH-1:0]  result_pair_tail,
  output logic                          result_stage_feedback_tail,
  output logic [RESULT_PAIR_WIDTH-2:0]  m_result_tdata,
  output logic                          m_result_tvalid,
  input  logic                          m_result_tready,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          err_overflow
`ifdef JOIN_CTRL_STATS_EN
  ,
  output logic [31:0]                   stat_stream_cnt,
  output logic [31:0]                   stat_window_cnt,
  output logic [31:0]                   stat_result_cnt,
  output logic [31:0]                   stat_stall_cycles
`endif
);

  localparam int SV = valid_idx(STREAM_TUPLE_WIDTH);
  localparam int WV = valid_idx(WINDOW_TUPLE_WIDTH);
  localparam int RV = valid_idx(RESULT_PAIR_WIDTH);
  localparam int CW = $clog2(RESULT_FIFO_DEPTH) + 1;
  localparam int QW = $clog2(2 * STAGE_NUM + 1);
  localparam int TW = $clog2(STAGE_NUM + 1);

  localparam logic [CW-1:0] STALL_THRESH = CW'(RESULT_FIFO_DEPTH - STALL_MARGIN);
  localparam logic [QW-1:0] QUIET_LAST   = QW'(2 * STAGE_NUM - 1);
  localparam logic [QW-1:0] QUIET_MAX    = QW'(2 * STAGE_NUM);
  localparam logic [TW-1:0] WAIT_LOAD    = TW'(STAGE_NUM);

  ctrl_state_e state_q, state_d;

  logic [STREAM_TUPLE_WIDTH-1:0] stream_head_q;
  logic [WINDOW_TUPLE_WIDTH-1:0] window_head_q;
  logic                          stream_consumed;
  logic                          window_consumed;
  logic                          stream_load;
  logic                          window_load;
  logic                          run_state;
  logic [QW-1:0]                 quiet_cnt_q;
  logic [TW-1:0]                 wait_cnt_q;
  logic                          quiet;
  logic [CW-1:0]                 fifo_count;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          result_valid;

  assign stream_consumed = stream_head_q[SV] & ~stream_stage_full_head;
  assign window_consumed = window_head_q[WV] & ~window_stage_full_head;

  // flush_req closes the inputs in the same cycle it is seen, before DRAIN.
  assign s_stream_tready = run_state & ~flush_req & (~stream_head_q[SV] | stream_consumed);
  assign s_window_tready = run_state & ~flush_req & (~window_head_q[WV] | window_consumed);
  assign stream_load     = s_stream_tvalid & s_stream_tready;
  assign window_load     = s_window_tvalid & s_window_tready;

  assign stream_tuple_head = stream_head_q;
  assign window_tuple_head = window_head_q;

  assign result_valid    = result_pair_tail[RV];
  assign m_result_tvalid = ~fifo_empty;

  assign quiet = ~stream_head_q[SV] & ~window_head_q[WV] & ~result_valid & fifo_empty;

  // Head registers: load on accept, empty out on consumption.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stream_head_q <= '0;
      window_head_q <= '0;
    end else begin
      if (stream_load)          stream_head_q <= {1'b1, s_stream_tdata};
      else if (stream_consumed) stream_head_q <= '0;
      if (window_load)          window_head_q <= {1'b1, s_window_tdata};
      else if (window_consumed) window_head_q <= '0;
    end
  end

  join_result_fifo #(
    .WIDTH (RESULT_PAIR_WIDTH - 1),
    .DEPTH (RESULT_FIFO_DEPTH)
  ) u_result_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (result_valid),
    .push_data (result_pair_tail[RV-1:0]),
    .pop       (m_result_tready),
    .pop_data  (m_result_tdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky overflow flag and registered stall feedback toward the chain tail.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_overflow               <= 1'b0;
      result_stage_feedback_tail <= 1'b0;
    end else begin
      if (result_valid & fifo_full) err_overflow <= 1'b1;
      result_stage_feedback_tail <= (fifo_count >= STALL_THRESH);
    end
  end

  // Quiet up-counter for DRAIN and clear-ripple down-counter for WAIT_CLR.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      quiet_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (state_q != ST_DRAIN || !quiet) quiet_cnt_q <= '0;
      else if (quiet_cnt_q != QUIET_MAX) quiet_cnt_q <= quiet_cnt_q + 1'b1;

      if (state_q == ST_CLEAR) wait_cnt_q <= WAIT_LOAD;
      else if (state_q == ST_WAIT_CLR && wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d                 = state_q;
    run_state               = 1'b0;
    stream_stage_clear_head = 1'b0;
    flush_done              = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN: begin
        run_state = 1'b1;
        if (flush_req) state_d = ST_DRAIN;
      end
      // Leave as the counter would reach 2*STAGE_NUM at this edge.
      ST_DRAIN: if (quiet && quiet_cnt_q == QUIET_LAST) state_d = ST_CLEAR;
      ST_CLEAR: begin
        stream_stage_clear_head = 1'b1;
        state_d                 = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (wait_cnt_q == '0) begin
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef JOIN_CTRL_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_stream_cnt   <= '0;
      stat_window_cnt   <= '0;
      stat_result_cnt   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (stream_consumed && stat_stream_cnt != '1) stat_stream_cnt <= stat_stream_cnt + 1'b1;
      if (window_consumed && stat_window_cnt != '1) stat_window_cnt <= stat_window_cnt + 1'b1;
      if (m_result_tvalid && m_result_tready && stat_result_cnt != '1)
        stat_result_cnt <= stat_result_cnt + 1'b1;
      if (result_stage_feedback_tail && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_join_chain_ctrl.sv
// Directed testbench for join_chain_ctrl (default build, statistics disabled).

module tb_join_chain_ctrl;

  localparam int SW     = 9;
  localparam int WW     = 9;
  localparam int RW     = 17;
  localparam int SN     = 4;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [SW-2:0] s_stream_tdata = '0;
  logic          s_stream_tvalid = 1'b0;
  logic          s_stream_tready;
  logic [WW-2:0] s_window_tdata = '0;
  logic          s_window_tvalid = 1'b0;
  logic          s_window_tready;
  logic [SW-1:0] stream_tuple_head;
  logic          stream_stage_full_head = 1'b0;
  logic          stream_stage_clear_head;
  logic [WW-1:0] window_tuple_head;
  logic          window_stage_full_head = 1'b0;
  logic [RW-1:0] result_pair_tail = '0;
  logic          result_stage_feedback_tail;
  logic [RW-2:0] m_result_tdata;
  logic          m_result_tvalid;
  logic          m_result_tready = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          err_overflow;

  join_chain_ctrl #(
    .STREAM_TUPLE_WIDTH (SW),
    .WINDOW_TUPLE_WIDTH (WW),
    .RESULT_PAIR_WIDTH  (RW),
    .STAGE_NUM          (SN),
    .RESULT_FIFO_DEPTH  (DEPTH),
    .STALL_MARGIN       (MARGIN)
  ) dut (
    .aclk                       (aclk),
    .aresetn                    (aresetn),
    .s_stream_tdata             (s_stream_tdata),
    .s_stream_tvalid            (s_stream_tvalid),
    .s_stream_tready            (s_stream_tready),
    .s_window_tdata             (s_window_tdata),
    .s_window_tvalid            (s_window_tvalid),
    .s_window_tready            (s_window_tready),
    .stream_tuple_head          (stream_tuple_head),
    .stream_stage_full_head     (stream_stage_full_head),
    .stream_stage_clear_head    (stream_stage_clear_head),
    .window_tuple_head          (window_tuple_head),
    .window_stage_full_head     (window_stage_full_head),
    .result_pair_tail           (result_pair_tail),
    .result_stage_feedback_tail (result_stage_feedback_tail),
    .m_result_tdata             (m_result_tdata),
    .m_result_tvalid            (m_result_tvalid),
    .m_result_tready            (m_result_tready),
    .flush_req                  (flush_req),
    .flush_done                 (flush_done),
    .err_overflow               (err_overflow)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_tready"}, s_stream_tready, 0);
    check({tag, "_w_tready"}, s_window_tready, 0);
    check({tag, "_s_head"}, stream_tuple_head, 0);
    check({tag, "_w_head"}, window_tuple_head, 0);
    check({tag, "_clear"}, stream_stage_clear_head, 0);
    check({tag, "_fb"}, result_stage_feedback_tail, 0);
    check({tag, "_m_tdata"}, m_result_tdata, 0);
    check({tag, "_m_tvalid"}, m_result_tvalid, 0);
    check({tag, "_done"}, flush_done, 0);
    check({tag, "_ovf"}, err_overflow, 0);
  endtask

  int last_act, clr_cnt, clr_cyc, done_cyc;
  bit seen;

  initial begin
    // Reset state
    #23;
    check_all_zero("reset");
    tick;
    aresetn = 1'b1;
    check("idle_tready", s_stream_tready, 0);
    tick;
    check("run_tready", s_stream_tready, 1);

    // Three stream tuples back to back
    s_stream_tvalid = 1'b1;
    s_stream_tdata  = 8'h11; tick; check("head_11", stream_tuple_head, 9'h111);
    s_stream_tdata  = 8'h22; tick; check("head_22", stream_tuple_head, 9'h122);
    s_stream_tdata  = 8'h33; tick; check("head_33", stream_tuple_head, 9'h133);
    s_stream_tvalid = 1'b0;  tick; check("head_empty", stream_tuple_head, 0);

    // Window path
    s_window_tvalid = 1'b1; s_window_tdata = 8'h5A;
    tick; check("whead_5a", window_tuple_head, 9'h15A);
    s_window_tvalid = 1'b0;
    tick; check("whead_empty", window_tuple_head, 0);

    // Stage 0 full stalls the head
    stream_stage_full_head = 1'b1;
    s_stream_tvalid = 1'b1; s_stream_tdata = 8'h44;
    tick; check("stall_load", stream_tuple_head, 9'h144);
    s_stream_tdata = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("stall_head", stream_tuple_head, 9'h144);
      check("stall_tready", s_stream_tready, 0);
    end
    stream_stage_full_head = 1'b0;
    #1; check("unstall_tready", s_stream_tready, 1);
    tick; check("unstall_head", stream_tuple_head, 9'h155);
    s_stream_tvalid = 1'b0;
    tick; check("unstall_empty", stream_tuple_head, 0);

    // Fill result FIFO with sink stalled; feedback rises one cycle after count=12
    m_result_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      result_pair_tail = {1'b1, 16'(16'hA000 + i)};
      tick;
      check("fill_fb", result_stage_feedback_tail, (i >= 12));
      if (i == 0) check("tail_latency", m_result_tvalid, 1);
    end
    check("fill_no_ovf", err_overflow, 0);
    result_pair_tail = {1'b1, 16'hBEEF};
    tick;
    check("ovf_set", err_overflow, 1);
    result_pair_tail = '0;
    tick;
    check("ovf_sticky", err_overflow, 1);
    check("ovf_head_kept", m_result_tdata, 16'hA000);
    m_result_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("pop_valid", m_result_tvalid, 1);
      check("pop_data", m_result_tdata, 16'(16'hA000 + i));
      tick;
    end
    check("drained_valid", m_result_tvalid, 0);
    tick;
    check("fb_released", result_stage_feedback_tail, 0);
    check("ovf_still_set", err_overflow, 1);

    // Flush during traffic
    s_stream_tvalid = 1'b1; s_stream_tdata = 8'h66;
    s_window_tvalid = 1'b1; s_window_tdata = 8'h77;
    tick;
    check("pre_flush_shead", stream_tuple_head, 9'h166);
    check("pre_flush_whead", window_tuple_head, 9'h177);
    flush_req = 1'b1;
    #1;
    check("flush_s_tready", s_stream_tready, 0);
    check("flush_w_tready", s_window_tready, 0);
    s_stream_tvalid = 1'b0; s_window_tvalid = 1'b0;
    stream_stage_full_head = 1'b1; window_stage_full_head = 1'b1;
    last_act = cyc; clr_cnt = 0; clr_cyc = -1000; done_cyc = -1;
    for (int k = 0; k < 200 && done_cyc < 0; k++) begin
      tick;
      if (stream_tuple_head[SW-1] || window_tuple_head[WW-1] ||
          result_pair_tail[RW-1] || m_result_tvalid) last_act = cyc;
      if (stream_stage_clear_head) begin clr_cnt++; clr_cyc = cyc; end
      if (flush_done) done_cyc = cyc;
      if (k == 0) flush_req = 1'b0;
      if (k == 3) begin stream_stage_full_head = 1'b0; window_stage_full_head = 1'b0; end
    end
    check("flush_done_seen", (done_cyc >= 0), 1);
    check("flush_done_time", done_cyc - last_act, 3 * SN + 2);
    check("clear_time", clr_cyc - last_act, 2 * SN + 1);
    check("clear_width", clr_cnt, 1);
    tick;
    check("flush_done_pulse", flush_done, 0);

    // Reset during WAIT_CLR aborts the flush
    flush_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick;
      if (stream_stage_clear_head) seen = 1'b1;
    end
    check("clear2_seen", seen, 1);
    tick; tick;
    check("wait_no_done", flush_done, 0);
    aresetn = 1'b0;
    flush_req = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int k = 0; k < 8; k++) begin
      tick;
      check("reset_no_done", flush_done, 0);
    end
    aresetn = 1'b1;
    check("reidle_tready", s_stream_tready, 0);
    tick;
    check("rerun_tready", s_stream_tready, 1);
    check("rerun_no_done", flush_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/join_chain_ctrl.md
# join_chain_ctrl

Head/tail controller for a linear chain of join core stages. Injects probe (stream) tuples and window tuples from two ready/valid sources into the chain head, and collects result pairs from the chain tail into a result FIFO. Throttles the chain through the result feedback stall and sequences a flush-and-clear of the chain on request. It sits between the kernel's input and output stream adapters and stage 0 / stage N-1 of the chain.

## Interface
Parameters:
- STREAM_TUPLE_WIDTH, `PARA_STREAM_TUPLE_WIDTH: width of a chain stream tuple; the MSB is the valid bit.
- WINDOW_TUPLE_WIDTH, `PARA_WINDOW_TUPLE_WIDTH: width of a chain window tuple; the MSB is the valid bit.
- RESULT_PAIR_WIDTH, `PARA_RESULT_PAIR_WIDTH: width of a chain result pair; the MSB is the valid bit.
- STAGE_NUM, 16: number of stages in the chain.
- RESULT_FIFO_DEPTH, 16: result FIFO entries; must be a power of 2 and at least 8.
- STALL_MARGIN, 4: free entries reserved to absorb results already in flight when a stall is raised.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: asynchronous, active-low reset.
- s_stream_tdata, in, STREAM_TUPLE_WIDTH-1: probe tuple payload.
- s_stream_tvalid / s_stream_tready, in / out, 1: probe tuple handshake.
- s_window_tdata, in, WINDOW_TUPLE_WIDTH-1: window tuple payload.
- s_window_tvalid / s_window_tready, in / out, 1: window tuple handshake.
- stream_tuple_head, out, STREAM_TUPLE_WIDTH: drives stage 0 stream_tuple_input.
- stream_stage_full_head, in, 1: stage 0 stream_stage_full_output.
- stream_stage_clear_head, out, 1: drives stage 0 stream_stage_clear_input.
- window_tuple_head, out, WINDOW_TUPLE_WIDTH: drives stage 0 window_tuple_input.
- window_stage_full_head, in, 1: stage 0 window_stage_full_output.
- result_pair_tail, in, RESULT_PAIR_WIDTH: the last stage's this_result_pair.
- result_stage_feedback_tail, out, 1: drives the last stage's result_stage_feedback_input.
- m_result_tdata, out, RESULT_PAIR_WIDTH-1: result payload.
- m_result_tvalid / m_result_tready, out / in, 1: result handshake.
- flush_req, in, 1: level request to flush the chain.
- flush_done, out, 1: one-cycle pulse when the flush completes.
- err_overflow, out, 1: sticky flag, set when a result arrives while the FIFO is full.

## Operation
- State machine: IDLE → RUN → DRAIN → CLEAR → WAIT_CLR → IDLE.
- IDLE: leave on reset release (next cycle) to RUN.
- RUN, head registers: one stream head register and one window head register; each holds {valid, payload}.
  - A head register loads when it is empty, or when it is consumed in the same cycle.
  - Consumed = valid & !*_full_head at that clock edge.
  - s_*_tready = RUN & (head empty | consumed).
- RUN → DRAIN when flush_req=1. Input tready drops in the same cycle; held head tuples are still delivered.
- DRAIN: a quiet counter counts consecutive cycles with both heads empty, no valid on result_pair_tail, and FIFO empty. Any activity resets it. Go to CLEAR when it reaches 2*STAGE_NUM.
- CLEAR: stream_stage_clear_head=1 for exactly one cycle.
- WAIT_CLR: wait STAGE_NUM+1 cycles, since clear ripples one stage per cycle. Then pulse flush_done and go to IDLE. If flush_req is still high, the next RUN → DRAIN transition happens immediately.
- Result path:
  - Every cycle with result_pair_tail MSB=1 pushes the payload into the FIFO.
  - If the FIFO is full: drop the result and set err_overflow. err_overflow clears only on reset.
- Feedback: result_stage_feedback_tail = registered (count >= RESULT_FIFO_DEPTH-STALL_MARGIN).
- Count arithmetic: $clog2(DEPTH)+1 bits. Simultaneous push and pop leave count unchanged.
- A pop while empty has no effect.

## Timing
- Reset values: all outputs 0. Head registers, FIFO, counters and state are cleared; state = IDLE.
- Reset mid-flush: abort immediately, no flush_done. Stages are not cleared by this block.
- Input to head latency: 1 cycle (tuple accepted at edge k appears on *_head after edge k).
- Head throughput: 1 tuple/cycle per path while *_full_head=0.
- Tail to m_result_tvalid latency: 1 cycle.
- Feedback:
  - Asserted 1 cycle after the threshold is crossed.
  - The chain honours it 1 cycle later.
  - STALL_MARGIN ≥ 3 guarantees no overflow when m_result_tready=0.
- flush_done: asserted exactly 2*STAGE_NUM + STAGE_NUM + 2 cycles after the last activity in DRAIN.

## Configuration
- JOIN_CTRL_STATS_EN defined: adds outputs stat_stream_cnt, stat_window_cnt, stat_result_cnt and stat_stall_cycles.
  - Each is 32 bits, saturating, and resets to 0.
  - They count head consumptions, FIFO pops, and cycles with result_stage_feedback_tail=1.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package: the state encoding localparams (IDLE, RUN, DRAIN, CLEAR, WAIT_CLR) and the valid-bit index helpers.
- Sub-module join_result_fifo: synchronous FIFO with asynchronous active-low reset, exposing count, full and empty.

## Test plan
- Reset release, 3 stream tuples 0x11/0x22/0x33 with stream_stage_full_head=0 → appear on the head on consecutive cycles with MSB=1, then head=0.
- stream_stage_full_head=1 held 5 cycles with a tuple waiting → head stable, s_stream_tready=0; tuple consumed on the cycle full drops.
- Tail emits 16 consecutive results with m_result_tready=0 (DEPTH 16, MARGIN 4) → feedback rises after count=12, err_overflow stays 0, all results are popped in order.
- Forced tail injection with the FIFO full → err_overflow=1 and sticky; FIFO contents unchanged.
- flush_req during traffic → tready drops, clear pulse is 1 cycle, flush_done arrives 3*STAGE_NUM+2 cycles after quiet.
- aresetn low in WAIT_CLR → all outputs 0, no flush_done, state IDLE.
